// File: rtl/regfile_multiport.sv
// Multi-read-port register file with a sequential clear engine and optional hardwired-zero entry 0.
// Optional write-to-read bypass is enabled by defining RF_FORWARD_EN.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok_s;

  // Clear engine state and address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the clear walks every entry once, then returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (&cnt_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_CLEAR;
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_ok_s = (state_q == ST_IDLE) && wen && !((ZERO_REG != 0) && (waddr == '0));
  assign busy    = (state_q == ST_CLEAR);

  // Storage array: the clear engine owns the write port while running
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_ok_s) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  // Read ports: busy gating has priority over the zero entry and over bypass
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (state_q == ST_CLEAR) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (raddr[k*ADDR_W +: ADDR_W] == '0)) begin
        rdata[k*DATA_W +: DATA_W] = '0;
`ifdef RF_FORWARD_EN
      end else if (wen && (raddr[k*ADDR_W +: ADDR_W] == waddr)) begin
        rdata[k*DATA_W +: DATA_W] = wdata;
`endif
      end else begin
        rdata[k*DATA_W +: DATA_W] = mem_q[raddr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: an array-plus-countdown model predicts every cycle's outputs.
module tb_regfile_multiport;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int ZERO_REG = 1;
  localparam int DEPTH    = 2 ** ADDR_W;

  logic                     clk;
  logic                     rst;
  logic                     clr_req;
  logic                     busy;
  logic                     wen;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;

  regfile_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                    tag;
    logic                     busy;
    logic [NUM_RD*DATA_W-1:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: contents plus the number of clear cycles still to run
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int                clear_left = DEPTH;

  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1,
                       input string tag);
    exp_t e;
    logic [ADDR_W-1:0] ra [NUM_RD];
    rst = r; clr_req = c; wen = w; waddr = wa; wdata = wd;
    ra[0] = ra0; ra[1] = ra1;
    raddr = {ra1, ra0};
    e.tag  = tag;
    e.busy = (clear_left > 0);
    e.rd   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [DATA_W-1:0] v;
      if (clear_left > 0) v = '0;
      else if (ZERO_REG != 0 && ra[k] == 0) v = '0;
`ifdef RF_FORWARD_EN
      else if (w && ra[k] == wa) v = wd;
`endif
      else v = mdl_mem[ra[k]];
      e.rd[k*DATA_W +: DATA_W] = v;
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (r) begin
      clear_left = DEPTH;
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) foreach (mdl_mem[i]) mdl_mem[i] = '0;
    end else begin
      if (w && !(ZERO_REG != 0 && wa == 0)) mdl_mem[wa] = wd;
      if (c) clear_left = DEPTH;
    end
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest prediction
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (busy !== e.busy) begin
        n_errors++;
        $display("FAIL %s busy: got %b expected %b at %0t", e.tag, busy, e.busy, $time);
      end
      for (int k = 0; k < NUM_RD; k++) begin
        n_checks++;
        if (rdata[k*DATA_W +: DATA_W] !== e.rd[k*DATA_W +: DATA_W]) begin
          n_errors++;
          $display("FAIL %s rdata[%0d]: got %h expected %h at %0t", e.tag, k,
                   rdata[k*DATA_W +: DATA_W], e.rd[k*DATA_W +: DATA_W], $time);
        end
      end
    end
  end

  initial begin
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    rst = 1'b1; clr_req = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    @(posedge clk); #1;

    // Reset, then the initial clear must last exactly DEPTH cycles
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd1, "reset");
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd3, "reset");
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b0, 1'b0, 1'b1, 5'd4, 32'h55, 5'(i), 5'(DEPTH - 1 - i), "init_clear");
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), "post_clear");

    // Basic write/read and the hardwired zero entry
    cycle(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, "write5");
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, "read5");
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'h1234, 5'd5, 5'd0, "write0");
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "read0");

    // Same-cycle read of the entry being written
    cycle(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, "same_cycle7");
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5, "next_cycle7");

    // Fill, clear request together with a write, writes ignored while busy
    for (int i = 1; i < DEPTH; i++)
      cycle(1'b0, 1'b0, 1'b1, 5'(i), 32'(i), 5'(i - 1), 5'(i), "fill");
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(DEPTH - 1 - i), "fill_read");
    cycle(1'b0, 1'b1, 1'b1, 5'd9, 32'h77, 5'd9, 5'd3, "clr_with_write");
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b0, (i % 5) == 0, 1'b1, 5'd3, 32'd9, 5'd3, 5'd9, "busy_write");
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), "after_clr");

    // Reset arriving mid-clear restarts the sweep
    for (int i = 1; i < 8; i++)
      cycle(1'b0, 1'b0, 1'b1, 5'(i), 32'hF0 + 32'(i), 5'(i), 5'd0, "refill");
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, "clr_req2");
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, "mid_clear");
    cycle(1'b1, 1'b0, 1'b1, 5'd6, 32'd1, 5'd5, 5'd6, "rst_mid");
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6, "rst_mid");
    for (int i = 0; i < DEPTH + 3; i++)
      cycle(1'b0, 1'b0, 1'b1, 5'(i), 32'hC0DE, 5'(i), 5'd6, "restart_clear");

    // Randomised traffic; narrow address range to force address collisions
    for (int i = 0; i < 3000; i++) begin
      logic r, c, w;
      logic [ADDR_W-1:0] wa, r0, r1;
      r  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        wa = 5'($urandom_range(0, 7)); r0 = 5'($urandom_range(0, 7)); r1 = 5'($urandom_range(0, 7));
      end else begin
        wa = 5'($urandom); r0 = 5'($urandom); r1 = 5'($urandom);
      end
      cycle(r, c, w, wa, 32'($urandom), r0, r1, "random");
    end

    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, "drain");
    @(negedge clk); #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
